// File: rtl/adc_capture_ad9226_if.sv
// Control and record-readback bundle for adc_capture_ad9226.
// master = host side (arms captures, reads the record), slave = capture engine.
interface adc_capture_ad9226_if #(
    parameter int DW = 12,
    parameter int AW = 10
);
    logic          Start;
    logic          Abort;
    logic [DW-1:0] Trig_Level;
    logic [7:0]    Decim;
    logic          Busy;
    logic          Done;
    logic          Ovr_flag;
    logic          Rd_en;
    logic [AW-1:0] Rd_addr;
    logic [DW-1:0] Rd_data;
    logic          Rd_valid;

    modport master (
        output Start, Abort, Trig_Level, Decim, Rd_en, Rd_addr,
        input  Busy, Done, Ovr_flag, Rd_data, Rd_valid
    );

    modport slave (
        input  Start, Abort, Trig_Level, Decim, Rd_en, Rd_addr,
        output Busy, Done, Ovr_flag, Rd_data, Rd_valid
    );
endinterface

// File: rtl/adc_capture_ad9226.sv
// Single-channel AD9226 capture: input register, decimator, optional rising-level trigger, record RAM.
// Build option ADC_TRIG_EN: when defined, Start arms a level trigger; otherwise Start captures at once.
module adc_capture_ad9226 #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int DW    = 12
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    output logic                 ADC_CLK,
    input  logic [DW-1:0]        ADC_Data,
    input  logic                 ADC_OTR,
    adc_capture_ad9226_if.slave  ctl
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPT, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] s_data_q;
    logic          s_otr_q;
    logic [7:0]    div_cnt_q, div_cnt_d;
    logic [7:0]    decim_q, decim_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic          ovr_q, ovr_d;
    logic          wr_en, tick, start_ok;
    logic [DW-1:0] rd_data_q;
    logic          rd_valid_q;
    logic [DW-1:0] mem_q [DEPTH];

`ifdef ADC_TRIG_EN
    logic [DW-1:0] trig_q, trig_d;
    logic [DW-1:0] prev_q, prev_d;
    logic          first_q, first_d;
    logic          trig_hit;

    // Rising crossing only: the previous ticked sample must sit below the level.
    assign trig_hit = !first_q && (prev_q < trig_q) && (s_data_q >= trig_q);
`else
    logic unused_trig;
    assign unused_trig = ^ctl.Trig_Level;
`endif

    // Inverted clock launches ADC data mid-cycle, well clear of the capture edge.
    assign ADC_CLK  = ~Clk;
    assign tick     = (div_cnt_q == 8'd0);
    assign start_ok = ctl.Start && (state_q == S_IDLE || state_q == S_DONE);

    assign ctl.Busy     = (state_q == S_ARM) || (state_q == S_CAPT);
    assign ctl.Done     = (state_q == S_DONE);
    assign ctl.Ovr_flag = ovr_q;
    assign ctl.Rd_data  = rd_data_q;
    assign ctl.Rd_valid = rd_valid_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            s_data_q  <= '0;
            s_otr_q   <= 1'b0;
            div_cnt_q <= '0;
            decim_q   <= '0;
            wr_addr_q <= '0;
            ovr_q     <= 1'b0;
`ifdef ADC_TRIG_EN
            trig_q    <= '0;
            prev_q    <= '0;
            first_q   <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            s_data_q  <= ADC_Data;
            s_otr_q   <= ADC_OTR;
            div_cnt_q <= div_cnt_d;
            decim_q   <= decim_d;
            wr_addr_q <= wr_addr_d;
            ovr_q     <= ovr_d;
`ifdef ADC_TRIG_EN
            trig_q    <= trig_d;
            prev_q    <= prev_d;
            first_q   <= first_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        div_cnt_d = (div_cnt_q == decim_q) ? 8'd0 : div_cnt_q + 8'd1;
        decim_d   = decim_q;
        wr_addr_d = wr_addr_q;
        ovr_d     = ovr_q;
        wr_en     = 1'b0;
`ifdef ADC_TRIG_EN
        trig_d    = trig_q;
        prev_d    = prev_q;
        first_d   = first_q;
`endif
        if (ctl.Abort) begin
            state_d = S_IDLE;
        end else if (start_ok) begin
            decim_d   = ctl.Decim;
            div_cnt_d = 8'd0;
            wr_addr_d = '0;
            ovr_d     = 1'b0;
`ifdef ADC_TRIG_EN
            trig_d    = ctl.Trig_Level;
            first_d   = 1'b1;
            state_d   = S_ARM;
`else
            state_d   = S_CAPT;
`endif
        end else begin
            case (state_q)
`ifdef ADC_TRIG_EN
                S_ARM: begin
                    if (tick) begin
                        prev_d  = s_data_q;
                        first_d = 1'b0;
                        if (trig_hit) begin
                            wr_en   = 1'b1;
                            state_d = S_CAPT;
                        end
                    end
                end
`endif
                S_CAPT: begin
                    if (tick) begin
                        wr_en = 1'b1;
                        if (wr_addr_q == AW'(DEPTH - 1)) state_d = S_DONE;
                    end
                end
                default: ;
            endcase
        end
        if (wr_en) begin
            wr_addr_d = wr_addr_q + 1'b1;
            ovr_d     = ovr_q | s_otr_q;
        end
    end

    // Record RAM is deliberately not reset so a capture survives Abort and reset.
    always_ff @(posedge Clk) begin
        if (wr_en) mem_q[wr_addr_q] <= s_data_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= ctl.Rd_en;
            if (ctl.Rd_en) rd_data_q <= mem_q[ctl.Rd_addr];
        end
    end

endmodule
